// File: rtl/phy_status_poller.sv
// Periodic MIIM reader of PHY BMSR/BMCR that publishes decoded link status.
// Each poll does three reads (BMSR discard, BMSR keep, BMCR keep) and updates the status outputs together.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a pending poll tick while enable=1
// S_REQ       | regad driven; pulses miim_rden as soon as the engine is idle
// S_WAIT_BUSY | waiting for the engine to go busy (or an early data strobe)
// S_WAIT_DATA | waiting for the read-data strobe
// S_NEXT      | advance to the next read, or go on to commit
// S_COMMIT    | publish captured status, pulse link_change if needed
module phy_status_poller #(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter int unsigned POLL_DIV = 1_000_000,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [4:0]  miim_phyad,
    output logic [4:0]  miim_regad,
    output logic        miim_rden,
    input  logic        miim_busy,
    input  logic [15:0] miim_rddata,
    input  logic        miim_rddata_valid,
    output logic        link_up,
    output logic        an_complete,
    output logic        speed_100,
    output logic        full_duplex,
    output logic        status_valid,
    output logic        link_change,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BUSY,
        S_WAIT_DATA,
        S_NEXT,
        S_COMMIT
    } state_t;

    localparam logic [23:0] POLL_LAST = 24'(POLL_DIV - 1);
    localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [23:0] poll_cnt;
    logic        poll_tick;
    logic        pending;
    logic [1:0]  step;
    logic [15:0] tmo_cnt;
    logic        in_wait;
    logic        tmo_hit;
    logic        start;
    logic        enter_req;
    logic        capture;
    logic        bmsr_link, bmsr_an, bmcr_spd, bmcr_fd;
    logic        unused_rddata;

    assign poll_tick  = (poll_cnt == POLL_LAST);
    assign in_wait    = (state == S_REQ) || (state == S_WAIT_BUSY) || (state == S_WAIT_DATA);
    assign tmo_hit    = in_wait && (tmo_cnt == 16'd0);
    assign start      = (state == S_IDLE) && pending && enable;
    assign enter_req  = start || ((state == S_NEXT) && (step != 2'd2));
    assign miim_phyad = PHY_ADDR;
    // Steps 0 and 1 read BMSR (reg 1), step 2 reads BMCR (reg 0).
    assign miim_regad = (in_wait && (step != 2'd2)) ? 5'd1 : 5'd0;

    assign unused_rddata = ^{miim_rddata[15:14], miim_rddata[12:9], miim_rddata[7:6],
                             miim_rddata[4:3], miim_rddata[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        miim_rden = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end else if (!miim_busy) begin
                    miim_rden = 1'b1;
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end else if (miim_rddata_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_NEXT;
                end else if (miim_busy) begin
                    state_nxt = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end else if (miim_rddata_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT:   state_nxt = (step == 2'd2) ? S_COMMIT : S_REQ;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            poll_cnt     <= 24'd0;
            pending      <= 1'b0;
            step         <= 2'd0;
            tmo_cnt      <= 16'd0;
            bmsr_link    <= 1'b0;
            bmsr_an      <= 1'b0;
            bmcr_spd     <= 1'b0;
            bmcr_fd      <= 1'b0;
            link_up      <= 1'b0;
            an_complete  <= 1'b0;
            speed_100    <= 1'b0;
            full_duplex  <= 1'b0;
            status_valid <= 1'b0;
            link_change  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            poll_cnt    <= poll_tick ? 24'd0 : poll_cnt + 24'd1;
            pending     <= poll_tick | (pending & ~start);
            link_change <= 1'b0;

            if (start) begin
                step <= 2'd0;
            end else if ((state == S_NEXT) && (step != 2'd2)) begin
                step <= step + 2'd1;
            end

            if (enter_req) begin
                tmo_cnt <= TMO_LOAD;
            end else if (in_wait && (tmo_cnt != 16'd0)) begin
                tmo_cnt <= tmo_cnt - 16'd1;
            end

            // The first BMSR read only flushes the latched-low link bit.
            if (capture && (step == 2'd1)) begin
                bmsr_link <= miim_rddata[2];
                bmsr_an   <= miim_rddata[5];
            end
            if (capture && (step == 2'd2)) begin
                bmcr_spd <= miim_rddata[13];
                bmcr_fd  <= miim_rddata[8];
            end

            if (tmo_hit) timeout_err <= 1'b1;

            if (state == S_COMMIT) begin
                link_up      <= bmsr_link;
                an_complete  <= bmsr_an;
                speed_100    <= bmcr_spd;
                full_duplex  <= bmcr_fd;
                status_valid <= 1'b1;
                timeout_err  <= 1'b0;
                link_change  <= status_valid && (bmsr_link != link_up);
            end
        end
    end

endmodule

// File: tb/tb_phy_status_poller.sv
// Randomized bench for phy_status_poller: a behavioural MIIM engine answers reads from a response queue,
// and a status model predicts the published outputs from the register values handed to the engine.
module tb_phy_status_poller;

    localparam logic [4:0] PHY  = 5'd3;
    localparam int         POLL = 32;
    localparam int         TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  miim_phyad, miim_regad;
    logic        miim_rden;
    logic        miim_busy;
    logic [15:0] miim_rddata;
    logic        miim_rddata_valid;
    logic        link_up, an_complete, speed_100, full_duplex, status_valid, link_change, timeout_err;

    logic        eng_busy = 1'b0, force_busy = 1'b0, eng_valid = 1'b0, stray_valid = 1'b0, eng_dead = 1'b0;
    logic [15:0] eng_data = 16'h0000;

    assign miim_busy         = eng_busy | force_busy;
    assign miim_rddata_valid = eng_valid | stray_valid;
    assign miim_rddata       = eng_data;

    int checks = 0, errors = 0;
    int served = 0, rden_cnt = 0, lc_cnt = 0, proto_viol = 0;
    logic [15:0] resp_q[$];
    logic [4:0]  req_log[$];
    logic m_link = 0, m_an = 0, m_spd = 0, m_fd = 0, m_valid = 0, m_tmo = 0;

    phy_status_poller #(.PHY_ADDR(PHY), .POLL_DIV(POLL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .miim_phyad(miim_phyad), .miim_regad(miim_regad), .miim_rden(miim_rden),
        .miim_busy(miim_busy), .miim_rddata(miim_rddata), .miim_rddata_valid(miim_rddata_valid),
        .link_up(link_up), .an_complete(an_complete), .speed_100(speed_100),
        .full_duplex(full_duplex), .status_valid(status_valid), .link_change(link_change),
        .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    // MIIM engine: sees a request, optionally goes busy for a few cycles, then strobes the data.
    initial begin : engine
        logic [15:0] d;
        int          lat;
        bit          fast;
        forever begin
            @(negedge clk); #1;
            if (miim_rden && !eng_dead) begin
                req_log.push_back(miim_regad);
                d    = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
                lat  = $urandom_range(0, 3);
                fast = ($urandom_range(0, 3) == 0);
                @(negedge clk); #2;
                if (!fast) begin
                    eng_busy = 1'b1;
                    repeat (lat + 1) begin @(negedge clk); #2; end
                    eng_busy = 1'b0;
                end
                eng_valid = 1'b1;
                eng_data  = d;
                @(negedge clk); #2;
                eng_valid = 1'b0;
                served++;
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (miim_rden) rden_cnt++;
        if (miim_rden && miim_busy) proto_viol++;
        if (link_change) lc_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk); #4;
    endtask

    task automatic finish_seq(input logic [15:0] b1, input logic [15:0] c, input int base_srv,
                              input int base_lc, input string tag);
        int          n;
        logic        e_lc;
        logic [5:0]  got, exp;
        logic [14:0] rq;
        n = 0;
        while (served < base_srv + 3 && n < 300) begin step(); n++; end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL %s read_done timeout served=%0d required=%0d", tag, served - base_srv, 3);
            return;
        end
        repeat (4) step();
        e_lc    = m_valid && (b1[2] != m_link);
        m_link  = b1[2]; m_an = b1[5]; m_spd = c[13]; m_fd = c[8];
        m_valid = 1'b1;  m_tmo = 1'b0;
        got = {link_up, an_complete, speed_100, full_duplex, status_valid, timeout_err};
        exp = {m_link, m_an, m_spd, m_fd, m_valid, m_tmo};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s status got=%b required=%b", tag, got, exp);
        end
        checks++;
        if ((lc_cnt - base_lc) != int'(e_lc)) begin
            errors++;
            $display("FAIL %s link_change_cycles got=%0d required=%0d", tag, lc_cnt - base_lc, int'(e_lc));
        end
        rq = (req_log.size() == 3) ? {req_log[0], req_log[1], req_log[2]} : 15'h7fff;
        checks++;
        if (rq !== {5'd1, 5'd1, 5'd0}) begin
            errors++;
            $display("FAIL %s regad_order got=%h required=%h (count %0d)", tag, rq, {5'd1, 5'd1, 5'd0},
                     req_log.size());
        end
    endtask

    task automatic run_seq(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] c,
                           input int drop_after, input string tag);
        int base_srv, base_rden, base_lc, n;
        resp_q.delete();
        req_log.delete();
        resp_q.push_back(b0); resp_q.push_back(b1); resp_q.push_back(c);
        base_srv = served; base_rden = rden_cnt; base_lc = lc_cnt;
        enable = 1'b1;
        n = 0;
        while (rden_cnt < base_rden + drop_after && n < 300) begin step(); n++; end
        enable = 1'b0;
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL %s start timeout rden=%0d required=%0d", tag, rden_cnt - base_rden, drop_after);
            return;
        end
        finish_seq(b1, c, base_srv, base_lc, tag);
    endtask

    task automatic test_reset();
        logic [16:0] got;
        rst = 1'b0; enable = 1'b0;
        repeat (3) step();
        got = {link_up, an_complete, speed_100, full_duplex, status_valid, link_change, timeout_err,
               miim_rden, miim_regad, 4'h0};
        checks++;
        if (got !== 17'd0) begin errors++; $display("FAIL reset outputs got=%b required=0", got); end
        checks++;
        if (miim_phyad !== PHY) begin errors++; $display("FAIL reset phyad got=%0d required=%0d", miim_phyad, PHY); end
        rst = 1'b1;
    endtask

    task automatic test_first_seq();
        run_seq(16'h0004, 16'h0024, 16'h2100, 1, "first_seq");
    endtask

    task automatic test_link_drop();
        run_seq(16'h0024, 16'h0000, 16'h2100, 1, "link_drop");
    endtask

    task automatic test_random();
        logic [15:0] b0, b1, c;
        for (int i = 0; i < 6; i++) begin
            b0 = 16'($urandom); b1 = 16'($urandom); c = 16'($urandom);
            run_seq(b0, b1, c, 1, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_timeout();
        int n, base;
        logic [5:0] got, exp;
        eng_dead = 1'b1;
        base = rden_cnt;
        enable = 1'b1;
        n = 0;
        while (rden_cnt == base && n < 300) begin step(); n++; end
        enable = 1'b0;
        n = 0;
        while (!timeout_err && n < 200) begin step(); n++; end
        checks++;
        if (n != TMO) begin errors++; $display("FAIL timeout latency got=%0d required=%0d", n, TMO); end
        m_tmo = 1'b1;
        got = {link_up, an_complete, speed_100, full_duplex, status_valid, timeout_err};
        exp = {m_link, m_an, m_spd, m_fd, m_valid, m_tmo};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL timeout status got=%b required=%b", got, exp); end
        base = rden_cnt;
        repeat (40) step();
        checks++;
        if (rden_cnt != base) begin errors++; $display("FAIL timeout idle rden got=%0d required=0", rden_cnt - base); end
        eng_dead = 1'b0;
        run_seq(16'h0000, 16'h0004, 16'h0100, 1, "after_timeout");
    endtask

    task automatic test_busy_hold();
        int base, base_srv, base_lc;
        logic [15:0] b1, c;
        b1 = 16'($urandom); c = 16'($urandom);
        resp_q.delete(); req_log.delete();
        resp_q.push_back(16'($urandom)); resp_q.push_back(b1); resp_q.push_back(c);
        base = rden_cnt; base_srv = served; base_lc = lc_cnt;
        force_busy = 1'b1;
        enable = 1'b1;
        repeat (40) step();
        checks++;
        if (rden_cnt != base) begin errors++; $display("FAIL busy_hold rden_while_busy got=%0d required=0", rden_cnt - base); end
        @(negedge clk);
        force_busy = 1'b0;
        #4;
        checks++;
        if (rden_cnt != base + 1) begin errors++; $display("FAIL busy_hold release_rden got=%0d required=1", rden_cnt - base); end
        enable = 1'b0;
        step();
        checks++;
        if (rden_cnt != base + 1) begin errors++; $display("FAIL busy_hold pulse_width got=%0d required=1", rden_cnt - base); end
        finish_seq(b1, c, base_srv, base_lc, "busy_hold");
    endtask

    task automatic test_enable_drop();
        int base;
        run_seq(16'($urandom), 16'($urandom), 16'($urandom), 2, "enable_drop");
        base = rden_cnt;
        repeat (3 * POLL) step();
        checks++;
        if (rden_cnt != base) begin errors++; $display("FAIL enable_drop idle rden got=%0d required=0", rden_cnt - base); end
        run_seq(16'($urandom), 16'($urandom), 16'($urandom), 1, "enable_restart");
    endtask

    task automatic test_reset_mid_read();
        int base, n;
        logic [16:0] got;
        resp_q.delete();
        resp_q.push_back(16'hffff); resp_q.push_back(16'hffff); resp_q.push_back(16'hffff);
        base = rden_cnt;
        enable = 1'b1;
        n = 0;
        while (rden_cnt == base && n < 300) begin step(); n++; end
        enable = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        stray_valid = 1'b1;
        step();
        stray_valid = 1'b0;
        repeat (40) step();
        got = {link_up, an_complete, speed_100, full_duplex, status_valid, link_change, timeout_err,
               miim_rden, miim_regad, 4'h0};
        checks++;
        if (got !== 17'd0) begin errors++; $display("FAIL reset_mid_read outputs got=%b required=0", got); end
        checks++;
        if (rden_cnt != base + 1) begin errors++; $display("FAIL reset_mid_read rden got=%0d required=1", rden_cnt - base); end
        m_link = 0; m_an = 0; m_spd = 0; m_fd = 0; m_valid = 0; m_tmo = 0;
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_viol != 0) begin errors++; $display("FAIL protocol rden_with_busy got=%0d required=0", proto_viol); end
    endtask

    initial begin
        test_reset();
        test_first_seq();
        test_link_drop();
        test_random();
        test_timeout();
        test_busy_hold();
        test_enable_drop();
        test_reset_mid_read();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
